// File: rtl/cia_pkg.sv
// Shared phase constants and sequencer states for the CIA bus sequencer.
// The E-clock period is ECNT_MAX+1 enabled 7 MHz cycles.
package cia_pkg;

  localparam int         ECNT_W       = 4;
  localparam logic [3:0] ECNT_MAX     = 4'd9;
  localparam logic [3:0] GRANT_PHASE  = 4'd5;
  localparam logic [3:0] E_HIGH_START = 4'd6;
  localparam logic [3:0] STROBE_PHASE = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/cia_eclk_gen.sv
// E-clock phase counter: ecnt steps 0..9 on each clk7_en; eclk marks the enabled ecnt=9 cycle.
// No latency beyond the phase register; no backpressure, frozen while clk7_en is low.
module cia_eclk_gen
  import cia_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  output logic [ECNT_W-1:0] ecnt,
  output logic              eclk
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ecnt <= '0;
    end else if (clk7_en) begin
      ecnt <= (ecnt == ECNT_MAX) ? '0 : ecnt + 4'd1;
    end
  end

  assign eclk = clk7_en && !reset && (ecnt == ECNT_MAX);

endmodule

// File: rtl/cia_bus_seq.sv
// Two-port CIA bus sequencer: round-robin grant at ecnt=5, one enabled strobe at ecnt=9, ack one clk later.
// Request-to-ack at most 20 E-phases (winner) / 30 (loser); a requester waits for ack, nothing is dropped.
module cia_bus_seq
  import cia_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic       cs0,
  input  logic       cs1,
  input  logic [3:0] rs0,
  input  logic [3:0] rs1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       eclk,
  output logic       aen_a,
  output logic       aen_b,
  output logic       rd,
  output logic       wr,
  output logic [3:0] rs,
  output logic [7:0] data_out,
  input  logic [7:0] data_in_a,
  input  logic [7:0] data_in_b
);

  logic [ECNT_W-1:0] ecnt;
  state_t            state, state_nxt;
  logic              gnt;
  logic              last_gnt;
  logic              pick;
  logic              grant_go;
  logic              capture;
  logic              access_on;
  logic              strobe_on;
  logic              we_q;
  logic              cs_q;
  logic [3:0]        rs_q;
  logic [7:0]        wdata_q;

  cia_eclk_gen u_eclk_gen (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .ecnt    (ecnt),
    .eclk    (eclk)
  );

  // Contention goes to the port not granted last; a lone requester always wins.
  assign pick = (req0 && req1) ? ~last_gnt : req1;

  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (clk7_en && (ecnt == GRANT_PHASE) && (req0 || req1)) begin
          state_nxt = ACCESS;
          grant_go  = 1'b1;
        end
      end
      ACCESS: begin
        if (clk7_en && (ecnt == STROBE_PHASE)) begin
          state_nxt = DONE;
          capture   = ~we_q;
        end
      end
      // DONE leaves on the next clk regardless of clk7_en so ack stays a single-clk pulse.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    access_on = (state == ACCESS) && (ecnt >= E_HIGH_START);
    strobe_on = access_on && (ecnt == STROBE_PHASE);
    rd        = access_on && !we_q;
    wr        = access_on && we_q;
    rs        = access_on ? rs_q : 4'd0;
    data_out  = access_on ? wdata_q : 8'd0;
    aen_a     = strobe_on && !cs_q;
    aen_b     = strobe_on && cs_q;
    ack0      = (state == DONE) && !gnt;
    ack1      = (state == DONE) && gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      cs_q     <= 1'b0;
      rs_q     <= 4'd0;
      wdata_q  <= 8'd0;
      rdata    <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant_go) begin
        gnt      <= pick;
        last_gnt <= pick;
        we_q     <= pick ? we1    : we0;
        cs_q     <= pick ? cs1    : cs0;
        rs_q     <= pick ? rs1    : rs0;
        wdata_q  <= pick ? wdata1 : wdata0;
      end
      if (capture) begin
        rdata <= cs_q ? data_in_b : data_in_a;
      end
    end
  end

endmodule

// File: tb/tb_cia_bus_seq.sv
// Directed bench for cia_bus_seq with a small CIA register model on both chip selects.
module tb_cia_bus_seq;

  logic       clk = 1'b0;
  logic       reset, clk7_en;
  logic       req0, req1, we0, we1, cs0, cs1;
  logic [3:0] rs0, rs1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       eclk, aen_a, aen_b, rd, wr;
  logic [3:0] rs;
  logic [7:0] data_out, data_in_a, data_in_b;

  logic [7:0] rega [16] = '{default: 8'h00};
  logic [7:0] regb [16] = '{default: 8'h00};
  logic       use_ovr;
  logic [7:0] dina_ovr;

  assign data_in_a = use_ovr ? dina_ovr : rega[rs];
  assign data_in_b = regb[rs];

  always #5 clk = ~clk;

  cia_bus_seq dut (
    .clk       (clk),
    .reset     (reset),
    .clk7_en   (clk7_en),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .cs0       (cs0),
    .cs1       (cs1),
    .rs0       (rs0),
    .rs1       (rs1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .eclk      (eclk),
    .aen_a     (aen_a),
    .aen_b     (aen_b),
    .rd        (rd),
    .wr        (wr),
    .rs        (rs),
    .data_out  (data_out),
    .data_in_a (data_in_a),
    .data_in_b (data_in_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor: counts enabled strobes, acks and E-clock periods, and updates the register model.
  int         n_eclk = 0, n_eclk_bad = 0, n_period_bad = 0;
  int         n_sa = 0, n_sb = 0, n_ack0 = 0, n_ack1 = 0;
  int         en_cnt = 0, last_e = 0;
  logic       have_e = 1'b0;
  logic       sa_rd = 1'b0, sb_wr = 1'b0;
  logic [7:0] sb_data = 8'h00;
  logic [3:0] sb_rs = 4'h0;

  always @(negedge clk) begin
    if (reset) have_e <= 1'b0;
    if (eclk && !clk7_en) n_eclk_bad <= n_eclk_bad + 1;
    if (clk7_en && !reset) begin
      en_cnt <= en_cnt + 1;
      if (eclk) begin
        n_eclk <= n_eclk + 1;
        if (have_e && (en_cnt - last_e != 10)) n_period_bad <= n_period_bad + 1;
        have_e <= 1'b1;
        last_e <= en_cnt;
      end
    end
    if (clk7_en && aen_a) begin
      n_sa  <= n_sa + 1;
      sa_rd <= rd;
      if (wr) rega[rs] <= data_out;
    end
    if (clk7_en && aen_b) begin
      n_sb    <= n_sb + 1;
      sb_wr   <= wr;
      sb_data <= data_out;
      sb_rs   <= rs;
      if (wr) regb[rs] <= data_out;
    end
    if (ack0) n_ack0 <= n_ack0 + 1;
    if (ack1) n_ack1 <= n_ack1 + 1;
  end

  int s_sa, s_sb, s_a0, s_a1, s_e, s_pb;

  task automatic snap();
    s_sa = n_sa; s_sb = n_sb; s_a0 = n_ack0; s_a1 = n_ack1; s_e = n_eclk; s_pb = n_period_bad;
  endtask

  task automatic wait_ack(input int maxc, output int cyc, output int port);
    cyc  = -1;
    port = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        cyc  = i;
        port = ack1 ? 1 : 0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int first_e, first_a, cyc, port, en_seen;

  initial begin
    reset = 1'b1; clk7_en = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
    rs0 = 4'h0; rs1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
    use_ovr = 1'b0; dina_ovr = 8'h00;
    do_reset(3);

    // Reset state, with clk7_en high to show reset dominates.
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_eclk", eclk, 0);
    check("rst_aen_a", aen_a, 0);
    check("rst_aen_b", aen_b, 0);
    check("rst_rd", rd, 0);
    check("rst_wr", wr, 0);
    check("rst_rs", rs, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rdata", rdata, 0);

    // Port 0 write 0xA5 to CIA-B reg 1.
    snap();
    req0 = 1'b1; we0 = 1'b1; cs0 = 1'b1; rs0 = 4'h1; wdata0 = 8'hA5;
    reset = 1'b0;
    first_e = -1; first_a = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (eclk && first_e < 0) first_e = i;
      if (ack0 && first_a < 0) first_a = i;
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    check("w_first_eclk", first_e, 9);
    check("w_ack_cycle", first_a, 10);
    check("w_strobe_b", n_sb - s_sb, 1);
    check("w_strobe_a", n_sa - s_sa, 0);
    check("w_data_out", sb_data, 8'hA5);
    check("w_rs", sb_rs, 4'h1);
    check("w_wr", sb_wr, 1);
    check("w_ack0", n_ack0 - s_a0, 1);
    check("w_ack1", n_ack1 - s_a1, 0);
    check("w_regb1", regb[1], 8'hA5);

    // Port 1 read of CIA-A reg 0 returning 0x3C; issued right at the grant phase.
    snap();
    req1 = 1'b1; we1 = 1'b0; cs1 = 1'b0; rs1 = 4'h0;
    use_ovr = 1'b1; dina_ovr = 8'h3C;
    wait_ack(40, cyc, port);
    req1 = 1'b0;
    check("r_ack_cycle", cyc, 5);
    check("r_ack_port", port, 1);
    check("r_rdata", rdata, 8'h3C);
    check("r_strobe_a", n_sa - s_sa, 1);
    check("r_rd", sa_rd, 1);
    dina_ovr = 8'hFF;
    repeat (15) @(posedge clk);
    #1;
    check("r_rdata_hold", rdata, 8'h3C);
    check("r_ack1", n_ack1 - s_a1, 1);
    check("r_ack0", n_ack0 - s_a0, 0);
    use_ovr = 1'b0;

    // Reset asserted at ecnt=7 inside a write access, with clk7_en low.
    do_reset(1);
    snap();
    req0 = 1'b1; we0 = 1'b1; cs0 = 1'b0; rs0 = 4'h2; wdata0 = 8'h55;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("ab_mid_wr", wr, 1);
    check("ab_mid_data", data_out, 8'h55);
    reset = 1'b1; clk7_en = 1'b0; req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ab_wr_off", wr, 0);
    check("ab_data_off", data_out, 0);
    reset = 1'b0; clk7_en = 1'b1;
    req1 = 1'b1; we1 = 1'b0; cs1 = 1'b1; rs1 = 4'h1;
    wait_ack(40, cyc, port);
    req1 = 1'b0;
    check("ab_next_cycle", cyc, 10);
    check("ab_next_port", port, 1);
    check("ab_readback_b1", rdata, 8'hA5);
    check("ab_no_strobe_a", n_sa - s_sa, 0);
    check("ab_no_ack0", n_ack0 - s_a0, 0);
    check("ab_rega2", rega[2], 8'h00);

    // Port 0 write whose req drops one cycle after the grant.
    snap();
    req0 = 1'b1; we0 = 1'b1; cs0 = 1'b0; rs0 = 4'h3; wdata0 = 8'h77;
    repeat (5) @(posedge clk);
    #1;
    req0 = 1'b0;
    check("dr_wr_active", wr, 1);
    wait_ack(30, cyc, port);
    check("dr_ack_cycle", cyc, 4);
    check("dr_ack_port", port, 0);
    check("dr_rega3", rega[3], 8'h77);
    check("dr_rdata_kept", rdata, 8'hA5);
    check("dr_ack0", n_ack0 - s_a0, 1);

    // Both ports requesting continuously from reset.
    do_reset(1);
    snap();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; cs0 = 1'b1; cs1 = 1'b1; rs0 = 4'h1; rs1 = 4'h1;
    reset = 1'b0;
    wait_ack(40, cyc, port);
    check("rr1_cycle", cyc, 10);
    check("rr1_port", port, 0);
    wait_ack(40, cyc, port);
    check("rr2_cycle", cyc, 9);
    check("rr2_port", port, 1);
    wait_ack(40, cyc, port);
    check("rr3_cycle", cyc, 9);
    check("rr3_port", port, 0);
    wait_ack(40, cyc, port);
    req0 = 1'b0; req1 = 1'b0;
    check("rr4_cycle", cyc, 9);
    check("rr4_port", port, 1);
    repeat (12) @(posedge clk);
    #1;
    check("rr_ack0_total", n_ack0 - s_a0, 2);
    check("rr_ack1_total", n_ack1 - s_a1, 2);

    // Random clk7_en gaps with a port 0 write of 0x5A to CIA-B reg 4.
    do_reset(1);
    snap();
    req0 = 1'b1; we0 = 1'b1; cs0 = 1'b1; rs0 = 4'h4; wdata0 = 8'h5A;
    reset = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 400 && en_seen < 45; i++) begin
      clk7_en = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      if (clk7_en) en_seen++;
      if (ack0) req0 = 1'b0;
    end
    clk7_en = 1'b0;
    #1;
    check("gap_eclk_count", n_eclk - s_e, 4);
    check("gap_period_bad", n_period_bad - s_pb, 0);
    check("gap_strobe_b", n_sb - s_sb, 1);
    check("gap_regb4", regb[4], 8'h5A);
    check("gap_ack0", n_ack0 - s_a0, 1);
    check("gap_eclk_low", eclk, 0);
    check("eclk_only_enabled", n_eclk_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cia_bus_seq.md
CIA_BUS_SEQ -- requirements
Module: cia_bus_seq

Interface
REQ-001 clk  input  1  system clock.
REQ-002 reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 clk7_en  input  1  7 MHz clock enable; all state advances only on clk edges with clk7_en=1.
REQ-004 req0, req1  input  1 each  access request, port 0 = CPU, port 1 = host/OSD.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 cs0, cs1  input  1 each  CIA select: 0 = CIA-A, 1 = CIA-B.
REQ-007 rs0, rs1  input  4 each  register select.
REQ-008 wdata0, wdata1  input  8 each  write data.
REQ-009 ack0, ack1  output  1 each  one-clk completion pulse.
REQ-010 rdata  output  8  read data of the last completed read.
REQ-011 eclk  output  1  E-clock tick, used as the timer count input for both CIAs.
REQ-012 aen_a, aen_b  output  1 each  CIA address enables.
REQ-013 rd, wr, rs[3:0], data_out[7:0]  output  CIA bus strobes, register select and write data.
REQ-014 data_in_a, data_in_b  input  8 each  CIA read data.

Function
REQ-015 Phase counter ecnt: 0..9; +1 per clk7_en; 9 wraps to 0.
REQ-016 eclk = 1 for exactly the one clk cycle where clk7_en=1 and ecnt=9.
REQ-017 States: IDLE, ACCESS, DONE.
REQ-018 IDLE: on clk7_en with ecnt=5 and any req high, grant one port, latch its we/cs/rs/wdata, go to ACCESS.
REQ-019 Arbitration: single requester wins. Both requesting: the port not granted last wins (round-robin).
REQ-020 ACCESS, ecnt 6..9: rs and data_out driven from the latched values. rd = ~we, wr = we.
REQ-021 aen_a or aen_b (per latched cs) is high only while ecnt=9, so each access produces exactly one clk7_en strobe. This protects read-clear and timer-load registers.
REQ-022 On clk7_en with ecnt=9 in ACCESS: on reads, capture the selected data_in into rdata. Go to DONE.
REQ-023 DONE: ackN of the granted port = 1 for exactly one clk cycle (the cycle after the capture edge), then IDLE. rdata holds until the next completed read.
REQ-024 Outside ACCESS: aen_a = aen_b = rd = wr = 0; rs = 0; data_out = 0.
REQ-025 Requests are sampled only at the grant point. A req dropped after grant does not abort the access, and ack still pulses. A requester drops req in the cycle it sees ack.
REQ-026 Max request-to-ack latency: 20 clk7_en periods for a winning port, 30 for a losing port.
REQ-027 clk7_en low: all state, outputs and ecnt frozen. eclk = 0.

Reset
REQ-028 Reset: ecnt = 0, state = IDLE, last-grant = port 1 (port 0 wins first contention), rdata = 0x00.
REQ-029 Reset: all outputs 0, including ack0/ack1, eclk, aen_a, aen_b, rd, wr.
REQ-030 Reset mid-access: the access is abandoned with no strobe and no ack. It overrides clk7_en gating.

Structure
REQ-031 Shared package cia_pkg holds: ECNT_MAX=9, GRANT_PHASE=5, E_HIGH_START=6, STROBE_PHASE=9, and the state enum.
REQ-032 One sub-module, cia_eclk_gen, contains ecnt and eclk. Arbiter and FSM stay in cia_bus_seq.

Verification
REQ-033 Port 0 write, cs=1, rs=0x1, wdata=0xA5: aen_b and wr high for exactly one clk7_en cycle at ecnt=9 with data_out=0xA5, then one ack0 pulse. Port B register reads back 0xA5.
REQ-034 Port 1 read, cs=0, rs=0x0, data_in_a=0x3C at ecnt=9: rdata=0x3C and ack1 pulses once. data_in_a changes afterwards do not alter rdata.
REQ-035 req0 and req1 held continuously from reset: grants alternate 0,1,0,1. Each access occupies one E period (10 clk7_en periods). No double acks.
REQ-036 Toggle clk7_en with random gaps: eclk and strobes occur only on enabled cycles. The period stays 10 clk7_en periods.
REQ-037 Assert reset at ecnt=7 during ACCESS: no aen strobe and no ack. After release, ecnt restarts at 0 and the next request is served normally.
REQ-038 req0 dropped one cycle after grant: the access still completes and ack0 pulses once.
